// File: rtl/ser_4bit_add_pkg.sv
// ser_add_pkg: shared width, counter width and FSM state type for the bit-serial adder
package ser_add_pkg;
  localparam int N = 4;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, ADD, DONE} ser_add_state_t;
endpackage

// File: rtl/ser_4bit_add_if.sv
// ser_add_if: start/done handshake bundle for the serial adder
//   master drives start, a, b and observes sum, cout, done; slave is the adder side
interface ser_add_if;
  import ser_add_pkg::*;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] sum;
  logic         cout;
  logic         done;
  modport master(output start, a, b, input sum, cout, done);
  modport slave(input start, a, b, output sum, cout, done);
endinterface

// File: rtl/ser_4bit_add_fa.sv
// full_adder: single-bit combinational full adder
//   a, b, cin in; s = a^b^cin, cout = majority(a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/ser_4bit_add.sv
// ser_4bit_add: bit-serial 4-bit unsigned adder, one bit per clock LSB first
//   clk, reset (sync active-high); bus.slave: start/a/b in, registered sum/cout/done out
module ser_4bit_add
  import ser_add_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  ser_add_if.slave  bus
);
  ser_add_state_t state_q, state_d;
  logic [N-1:0]   a_sr_q, a_sr_d, b_sr_q, b_sr_d, ps_q, ps_d, sum_q, sum_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d, cout_q, cout_d, done_q, done_d;
  logic           fa_s, fa_c;
  full_adder u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_c)
  );
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    ps_d    = ps_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = done_q;
    if (state_q == ADD) begin
      a_sr_d  = a_sr_q >> 1;
      b_sr_d  = b_sr_q >> 1;
      ps_d    = {fa_s, ps_q[N-1:1]};
      carry_d = fa_c;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) begin
        sum_d   = {fa_s, ps_q[N-1:1]};
        cout_d  = fa_c;
        done_d  = 1'b1;
        state_d = DONE;
      end
    end else if (bus.start) begin
      a_sr_d  = bus.a;
      b_sr_d  = bus.b;
      carry_d = 1'b0;
      cnt_d   = '0;
      done_d  = 1'b0;
      state_d = ADD;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      ps_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_ser_4bit_add.sv
// tb_ser_4bit_add: scoreboard bench for the serial adder
module tb_ser_4bit_add;
  typedef struct {
    logic [4:0] res;
    int         acc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic done_prev = 1'b0;
  exp_t sb[$];
  ser_add_if bus();
  ser_4bit_add dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  always @(negedge clk) begin
    exp_t e;
    if (reset) done_prev = 1'b0;
    else begin
      if (bus.done && !done_prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done got {cout,sum}=%h at cycle %0d", {bus.cout, bus.sum}, cyc);
        end else begin
          e = sb.pop_front();
          if ({bus.cout, bus.sum} !== e.res) begin
            errors++;
            $display("FAIL result got %h expected %h (accepted cycle %0d)", {bus.cout, bus.sum}, e.res, e.acc);
          end
          checks++;
          if (cyc - e.acc != 4) begin
            errors++;
            $display("FAIL latency got %0d expected 4", cyc - e.acc);
          end
        end
      end
      done_prev = bus.done;
    end
  end
  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp, input bit push);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    if (push) sb.push_back('{exp, cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = bus.done;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout got done=0 expected done=1");
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.done, bus.cout, bus.sum}, 6'h00);
    reset = 1'b0;
    @(negedge clk);
    issue(4'hF, 4'h1, 5'h10, 1);
    wait_done();
    issue(4'h7, 4'h9, 5'h10, 1);
    wait_done();
    issue(4'h0, 4'h0, 5'h00, 1);
    wait_done();
    issue(4'hF, 4'hF, 5'h1E, 1);
    wait_done();
    issue(4'h3, 4'h4, 5'h07, 1);
    bus.a = 4'hF;
    bus.b = 4'hF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    issue(4'h2, 4'h3, 5'h05, 1);
    wait_done();
    bus.a = 4'h5;
    bus.b = 4'h6;
    bus.start = 1'b1;
    sb.push_back('{5'h0B, cyc + 1});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_hold", {bus.done, bus.cout, bus.sum}, 6'h05);
    end
    wait_done();
    issue(4'h9, 4'h9, 5'h00, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_add", {bus.done, bus.cout, bus.sum}, 6'h00);
    reset = 1'b0;
    @(negedge clk);
    issue(4'h9, 4'h9, 5'h12, 1);
    wait_done();
    bus.start = 1'b1;
    bus.a = 4'h1;
    bus.b = 4'h2;
    sb.push_back('{5'h03, cyc + 1});
    repeat (5) @(negedge clk);
    bus.a = 4'h8;
    bus.b = 4'h8;
    sb.push_back('{5'h10, cyc + 1});
    repeat (5) @(negedge clk);
    bus.a = 4'hF;
    bus.b = 4'hF;
    sb.push_back('{5'h1E, cyc + 1});
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        issue(4'(x), 4'(y), 5'(x + y), 1);
        wait_done();
      end
    repeat (6) @(negedge clk);
    check("scoreboard_empty", 6'(sb.size()), 6'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
